// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg: shared receiver state encoding and oversampling constants.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  localparam int OSR    = 16;
  localparam int SCNT_W = $clog2(OSR);

  localparam logic [SCNT_W-1:0] SAMP_A    = SCNT_W'(7);
  localparam logic [SCNT_W-1:0] SAMP_B    = SCNT_W'(8);
  localparam logic [SCNT_W-1:0] SAMP_C    = SCNT_W'(9);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OSR - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo_buf.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo_buf: circular FIFO with extra-MSB pointers and combinational head.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo_buf #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_pop, do_push;

  always_comb begin
    empty    = (wptr_q == rptr_q);
    full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop_data = mem_q[rptr_q[AW-1:0]];
    do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = push_data;
      wptr_d                = wptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo: 16x oversampled UART receiver with error flags and receive FIFO.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_ferr,
  output logic                 rd_perr,
  output logic                 overrun,
  input  logic                 ovr_clr,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_e             state_q, state_d;
  logic                  sync1_q, sync2_q;
  logic [DIV_W-1:0]      tcnt_q, tcnt_d;
  logic [SCNT_W-1:0]     scnt_q, scnt_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  s7_q, s7_d, s8_q, s8_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                  perr_q, perr_d, ferr_q, ferr_d;
  logic                  push_q, push_d;
  logic                  ovr_q, ovr_d;
  logic                  rx_s, tick, mid, last, maj;
  logic                  pop, full, empty;
  logic [DATA_BITS+1:0]  head;

  always_comb begin
    rx_s    = sync2_q;
    tick    = (state_q != IDLE) && (tcnt_q == baud_div);
    mid     = tick && (scnt_q == SAMP_C);
    last    = tick && (scnt_q == SCNT_LAST);
    maj     = maj3(s7_q, s8_q, rx_s);
    state_d = state_q;
    tcnt_d  = (state_q == IDLE || tick) ? '0 : tcnt_q + DIV_W'(1);
    scnt_d  = tick ? scnt_q + SCNT_W'(1) : scnt_q;
    bcnt_d  = bcnt_q;
    s7_d    = (tick && scnt_q == SAMP_A) ? rx_s : s7_q;
    s8_d    = (tick && scnt_q == SAMP_B) ? rx_s : s8_q;
    shreg_d = shreg_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push_d  = 1'b0;
    case (state_q)
      IDLE: begin
        scnt_d = '0;
        bcnt_d = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (mid && maj) state_d = IDLE;
        else if (last)  state_d = DATA;
      end
      DATA: begin
        if (mid) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        if (last) begin
          bcnt_d = bcnt_q + BW'(1);
          if (bcnt_q == LAST_BIT) begin
            bcnt_d  = '0;
            state_d = parity_en ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (mid)  perr_d = (^shreg_q) ^ maj ^ parity_odd;
        if (last) state_d = STOP;
      end
      STOP: begin
        // Hold STOP through the push cycle so the entry fields stay stable.
        if (push_q) begin
          state_d = ferr_q ? BREAK : IDLE;
        end else if (mid) begin
          ferr_d = ~maj;
          push_d = 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop      = rd_ready & ~empty;
    ovr_d    = (push_q & full & ~pop) | (ovr_q & ~ovr_clr);
    rd_valid = ~empty;
    rd_data  = head[DATA_BITS-1:0];
    rd_ferr  = head[DATA_BITS];
    rd_perr  = head[DATA_BITS+1];
    overrun  = ovr_q;
    busy     = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      s7_q    <= 1'b1;
      s8_q    <= 1'b1;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      push_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= rx;
      sync2_q <= sync1_q;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      s7_q    <= s7_d;
      s8_q    <= s8_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      push_q  <= push_d;
      ovr_q   <= ovr_d;
    end
  end

  uart_rx_fifo_buf #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data ({perr_q, ferr_q, shreg_q}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fifo: directed frames with hand-computed expected FIFO entries.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_fifo;

  localparam int BIT_CLK = 80;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        rd_ready = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        rd_valid, rd_ferr, rd_perr, overrun, busy;
  logic [7:0]  rd_data;

  int n_cmp = 0;
  int n_bad = 0;
  int lat   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_BITS  (8),
    .FIFO_DEPTH (4),
    .DIV_W      (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_ferr    (rd_ferr),
    .rd_perr    (rd_perr),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle(BIT_CLK);
  endtask

  // Leaves rx at the stop-bit level so a held-low break can follow.
  task automatic send_frame(input logic [7:0] d, input bit use_par, input logic pbit,
                            input logic stopb);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (use_par) drive_bit(pbit);
    drive_bit(stopb);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] d, input logic fe,
                            input logic pe);
    check_val({tag, "_valid"}, rd_valid, 1);
    check_val({tag, "_data"}, rd_data, d);
    check_val({tag, "_ferr"}, rd_ferr, fe);
    check_val({tag, "_perr"}, rd_perr, pe);
    rd_ready = 1'b1;
    idle(1);
    rd_ready = 1'b0;
  endtask

  initial begin
    idle(4);
    check_val("rst_valid", rd_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ovr", overrun, 0);
    check_val("rst_data", rd_data, 0);
    reset = 1'b0;
    idle(5);

    // Basic 8N1 frame; also measures rx-fall to rd_valid latency.
    fork
      send_frame(8'hA5, 0, 1'b0, 1'b1);
      begin
        lat = 0;
        do begin
          idle(1);
          lat++;
        end while (!rd_valid && lat < 2000);
      end
    join
    check_val("basic_lat_range", (lat >= 720 && lat <= 800), 1);
    check_val("basic_busy", busy, 0);
    pop_expect("basic", 8'hA5, 1'b0, 1'b0);
    check_val("basic_empty", rd_valid, 0);

    // Parity: even good, even bad, odd good.
    parity_en = 1'b1;
    send_frame(8'h07, 1, 1'b1, 1'b1);
    idle(10);
    pop_expect("par_even_ok", 8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1, 1'b0, 1'b1);
    idle(10);
    pop_expect("par_even_bad", 8'h07, 1'b0, 1'b1);
    parity_odd = 1'b1;
    send_frame(8'h07, 1, 1'b0, 1'b1);
    idle(10);
    pop_expect("par_odd_ok", 8'h07, 1'b0, 1'b0);
    parity_en  = 1'b0;
    parity_odd = 1'b0;

    // Short low glitch is a false start.
    rx = 1'b0;
    idle(20);
    check_val("glitch_busy_mid", busy, 1);
    rx = 1'b1;
    idle(100);
    check_val("glitch_busy_end", busy, 0);
    check_val("glitch_nopush", rd_valid, 0);

    // Framing error followed by a long break gives one entry.
    send_frame(8'h55, 0, 1'b0, 1'b0);
    idle(3 * 10 * BIT_CLK);
    check_val("brk_busy", busy, 1);
    rx = 1'b1;
    idle(50);
    check_val("brk_idle", busy, 0);
    pop_expect("frm", 8'h55, 1'b1, 1'b0);
    check_val("frm_single", rd_valid, 0);

    // Overrun with five frames into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 0, 1'b0, 1'b1);
      idle(10);
      if (i == 4) check_val("ovr_before", overrun, 0);
    end
    check_val("ovr_set", overrun, 1);
    for (int i = 1; i <= 4; i++) pop_expect("ovr_pop", 8'(i), 1'b0, 1'b0);
    check_val("ovr_drained", rd_valid, 0);
    check_val("ovr_sticky", overrun, 1);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    check_val("ovr_cleared", overrun, 0);

    // Full FIFO: pop lands on the push cycle.
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h11 + 8'(i), 0, 1'b0, 1'b1);
      idle(10);
    end
    check_val("coin_full_ovr", overrun, 0);
    fork
      send_frame(8'h15, 0, 1'b0, 1'b1);
      begin
        repeat (lat - 1) @(posedge clk);
        #1;
        rd_ready = 1'b1;
        idle(1);
        rd_ready = 1'b0;
      end
    join
    idle(10);
    check_val("coin_ovr", overrun, 0);
    pop_expect("coin_p1", 8'h12, 1'b0, 1'b0);
    pop_expect("coin_p2", 8'h13, 1'b0, 1'b0);
    pop_expect("coin_p3", 8'h14, 1'b0, 1'b0);
    pop_expect("coin_p4", 8'h15, 1'b0, 1'b0);
    check_val("coin_empty", rd_valid, 0);

    // Reset during data bit 3 with an entry already queued.
    send_frame(8'h42, 0, 1'b0, 1'b1);
    idle(10);
    check_val("mrst_pre_valid", rd_valid, 1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b0;
    idle(40);
    check_val("mrst_pre_busy", busy, 1);
    reset = 1'b1;
    rx    = 1'b1;
    idle(1);
    check_val("mrst_valid", rd_valid, 0);
    check_val("mrst_data", rd_data, 0);
    check_val("mrst_ferr", rd_ferr, 0);
    check_val("mrst_perr", rd_perr, 0);
    check_val("mrst_ovr", overrun, 0);
    check_val("mrst_busy", busy, 0);
    reset = 1'b0;
    idle(20);
    send_frame(8'h3C, 0, 1'b0, 1'b1);
    idle(10);
    pop_expect("mrst_after", 8'h3C, 1'b0, 1'b0);
    check_val("mrst_after_empty", rd_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Synthesizable, parametrised UART receiver with a small receive FIFO, used for the serial console input path of the CPU.
- The line is 16x oversampled with a runtime divisor, so one build serves any baud rate the clock supports.
- Adds behaviour a plain sniffer lacks: majority-vote sampling, false-start rejection, optional parity, framing/parity error flags, and overrun detection.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8), sent LSB first.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2, at least 2.
- DIV_W, 16, width of the baud divisor port.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idles high.
- baud_div  in  DIV_W  oversample tick period minus 1, in clk cycles (tick every baud_div+1 clocks).
- parity_en  in  1  1 = a parity bit follows the data bits.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  consumer pops the head entry when rd_valid is also 1.
- rd_data  out  DATA_BITS  head entry data.
- rd_ferr  out  1  head entry had a framing error.
- rd_perr  out  1  head entry had a parity error (0 when parity_en=0).
- overrun  out  1  sticky flag: a frame was dropped because the FIFO was full.
- ovr_clr  in  1  clears overrun.
- busy  out  1  receiver is not in IDLE.

Behaviour:
- Reset: every output is 0; FIFO is empty; state is IDLE; tick counter is 0. A reset mid-frame discards the partial frame.
- rx passes through a 2-flop synchroniser before any use; this adds 2 cycles of latency.
- Tick generator: a DIV_W-bit counter pulses tick when it reaches baud_div, then reloads to 0. It free-runs only while the FSM is not in IDLE. baud_div is read at every reload.
- Sample counter: scnt counts 0..15 on ticks. At scnt 7, 8 and 9 it captures a sample, and the bit value is the majority of the three samples.
- IDLE: stays here while the synchronised rx is 1. When rx is 0, go to START with scnt=0 and the tick counter cleared.
- START: at scnt=9, a majority of 1 is a false start and returns to IDLE with nothing pushed. A majority of 0 continues. At scnt=15 go to DATA.
- DATA: each bit takes 16 ticks. The majority bit shifts in from the MSB side, giving LSB-first order. After DATA_BITS bits, go to PARITY if parity_en, else STOP.
- PARITY: perr = XOR(data bits, parity bit, parity_odd).
- STOP: at scnt=9, a majority of 0 sets ferr=1. The push happens on the cycle after this decision.
- After the push:
  - If ferr=0, go to IDLE.
  - If ferr=1, go to BREAK, which waits until the synchronised rx is 1 and then goes to IDLE. A held-low line therefore yields exactly one entry.
- Push: writes {perr, ferr, data}.
- Full FIFO at push: the frame is dropped, overrun is set, and FIFO contents are unchanged.
- Simultaneous push and pop when full: the pop takes effect first, so the push succeeds and overrun is not set.
- Simultaneous overrun set and ovr_clr: set wins.
- FIFO: circular buffer with log2(FIFO_DEPTH)+1-bit read and write pointers. Full means the MSBs differ and the low bits are equal. Pointers wrap modulo 2*FIFO_DEPTH.
  - rd_data, rd_ferr and rd_perr are combinational from the head entry and are valid whenever rd_valid=1.
  - A pop on an empty FIFO is ignored.
  - rd_valid rises the cycle after the push.
- Changing baud_div, parity_en or parity_odd mid-frame is undefined. The bench must only change them while busy=0.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the sample-point constants (7, 8, 9);
  - the oversample constant 16.
- One sub-module: uart_rx_fifo_buf (parametrised FIFO with push, pop, full, empty, and a width parameter). The receiver FSM, tick generator and synchroniser stay in uart_rx_fifo.

Test Plan:
- Basic frame: baud_div=4, parity_en=0, send 0xA5 8N1 (80 clk/bit) -> rd_valid=1, rd_data=0xA5, rd_ferr=0, rd_perr=0; rd_ready pulse -> rd_valid=0.
- Parity: parity_en=1, parity_odd=0, send 0x07 with parity bit 1 -> perr=0. Send 0x07 with parity bit 0 -> rd_perr=1, data=0x07.
- Glitch and framing:
  - a 20-cycle low glitch on rx -> no push, busy returns to 0;
  - a frame with stop bit 0 -> one entry with ferr=1; rx then held low for 3 frame times -> no further entries.
- Overrun: send 5 frames 0x01..0x05 with no pops, FIFO_DEPTH=4 -> overrun=1; pops return 0x01..0x04 and then rd_valid=0. ovr_clr -> overrun=0.
- Full-FIFO pop and push coincide: FIFO full, rd_ready=1 on the push cycle -> overrun stays 0 and the 4th pop returns the new byte.
- Reset mid-frame: assert reset during DATA bit 3 -> the next cycle shows all outputs 0; the following clean frame 0x3C is received correctly.
